// File: rtl/fir_out_decimator_if.sv
// fir_out_decimator_if: sample input strobe and decimated valid/ready output of fir_out_decimator.
interface fir_out_decimator_if #(parameter int DW = 16);
    logic [DW-1:0] din;
    logic          din_vld;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy;
    modport master(output din, din_vld, out_rdy, input out_data, out_vld);
    modport slave(input din, din_vld, out_rdy, output out_data, out_vld);
endinterface

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: averages every 2**DEC_LOG2 samples into a small valid/ready output FIFO.
// Define FIR_DEC_ROUND_EN to round half up instead of truncating the mean.
module fir_out_decimator #(
    parameter int DW       = 16,
    parameter int DEC_LOG2 = 2,
    parameter int FIFO_AW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    fir_out_decimator_if.slave   bus,
    output logic                 ovf,
    output logic [7:0]           drop_cnt
);
    localparam int N     = 1 << DEC_LOG2;
    localparam int AW    = DW + DEC_LOG2;
    localparam int DEPTH = 1 << FIFO_AW;

    logic [AW-1:0]       acc;
    logic [DEC_LOG2-1:0] phase;
    logic [DW-1:0]       mem [DEPTH];
    logic [FIFO_AW:0]    wptr, rptr;
    logic [AW-1:0]       sum, shifted;
    logic [DW-1:0]       result;
    logic                last, full, pop, drop;

    assign sum  = acc + AW'(bus.din);
    assign last = bus.din_vld && (phase == DEC_LOG2'(N - 1));
`ifdef FIR_DEC_ROUND_EN
    // Headroom holds: N*(2**DW-1) + N/2 still fits in AW bits and the mean stays <= 2**DW-1.
    assign shifted = (sum + AW'(N / 2)) >> DEC_LOG2;
`else
    assign shifted = sum >> DEC_LOG2;
`endif
    assign result = shifted[DW-1:0];

    assign full         = (wptr[FIFO_AW] != rptr[FIFO_AW]) && (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign bus.out_vld  = wptr != rptr;
    assign bus.out_data = mem[rptr[FIFO_AW-1:0]];
    assign pop          = bus.out_vld && bus.out_rdy;
    assign drop         = last && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            phase    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            acc      <= '0;
            phase    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (bus.din_vld) begin
                acc   <= last ? '0 : sum;
                phase <= last ? '0 : phase + 1'b1;
            end
            // A pop in the same edge frees the head slot, so a full FIFO still accepts the push.
            if (last && (!full || pop)) begin
                mem[wptr[FIFO_AW-1:0]] <= result;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: directed and random checks of fir_out_decimator against a queue-based model.
module tb_fir_out_decimator;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       ovf;
    logic [7:0] drop_cnt;
    int         n_chk = 0;
    int         n_pass = 0;
    int         q[$];
    int         m_sum = 0;
    int         m_cnt = 0;
    int         m_ovf = 0;
    int         m_drop = 0;
    int         frames = 0;

    fir_out_decimator_if #(.DW(16)) bus();

    fir_out_decimator dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int mean(input int s);
`ifdef FIR_DEC_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        m_sum = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_drop = 0;
    endtask

    task automatic model(input bit v, input int d, input bit r, input bit c);
        bit was_full, pop;
        if (c) begin
            model_clear();
            return;
        end
        was_full = q.size() == DEPTH;
        pop = q.size() > 0 && r;
        if (pop) void'(q.pop_front());
        if (v) begin
            m_sum += d;
            m_cnt++;
            if (m_cnt == N) begin
                frames++;
                if (!was_full || pop) q.push_back(mean(m_sum));
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("out_vld", bus.out_vld, q.size() != 0);
        if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
        chk("ovf", ovf, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic step(input bit v, input int d, input bit r, input bit c);
        bus.din_vld = v;
        bus.din = 16'(d);
        bus.out_rdy = r;
        clr = c;
        @(posedge clk);
        model(v, d, r, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #3;
        chk("rst_vld", bus.out_vld, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d, input bit r);
        step(1, a, r, 0);
        step(1, b, r, 0);
        step(1, c, r, 0);
        step(1, d, r, 0);
    endtask

    initial begin
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.out_rdy = 1'b0;
        do_reset();
        step(0, 0, 0, 0);
        frame(10, 20, 30, 40, 0);
        chk("t1_vld", bus.out_vld, 1);
        chk("t1_mean", bus.out_data, 25);
        step(0, 0, 1, 0);
        frame(1, 2, 2, 2, 0);
`ifdef FIR_DEC_ROUND_EN
        chk("t2_round", bus.out_data, 2);
`else
        chk("t2_trunc", bus.out_data, 1);
`endif
        step(0, 0, 1, 0);
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
        chk("t2_max", bus.out_data, 16'hFFFF);
        step(0, 0, 1, 0);
        chk("t2_empty", bus.out_vld, 0);
        for (int i = 0; i < 5; i++) frame(8, 8, 8, 8, 0);
        chk("t3_ovf", ovf, 1);
        chk("t3_drop", drop_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_head", bus.out_data, 8);
            step(0, 0, 1, 0);
        end
        chk("t3_drained", bus.out_vld, 0);
        do_reset();
        for (int i = 0; i < 4; i++) frame(i, i, i, i, 0);
        step(1, 50, 0, 0);
        step(1, 50, 0, 0);
        step(1, 50, 0, 0);
        step(1, 50, 1, 0);
        chk("t4_ovf", ovf, 0);
        chk("t4_drop", drop_cnt, 0);
        chk("t4_head", bus.out_data, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("t4_drained", bus.out_vld, 0);
        step(1, 100, 1, 0);
        step(1, 100, 1, 0);
        do_reset();
        frame(8, 8, 8, 8, 0);
        chk("t5_rst", bus.out_data, 8);
        step(0, 0, 1, 0);
        step(1, 100, 1, 0);
        step(1, 100, 1, 0);
        step(0, 0, 0, 1);
        frame(8, 8, 8, 8, 0);
        chk("t5_clr", bus.out_data, 8);
        step(0, 0, 1, 1);
        while (frames < 1000)
            step($urandom_range(0, 2) != 0, int'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 999) == 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("final_empty", bus.out_vld, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
